// File: rtl/fir_unf_sched_if.sv
// fir_unf_sched_if: bundle of the serial stream, filter triplet, config and
// coefficient signals around the unfolded-FIR scheduler.
// With FIR_SCHED_ERR_EN defined the bundle also carries ERR and CNT_TRIP.
interface fir_unf_sched_if #(
    parameter int NBIT = 9,
    parameter int NTAP = 11
);
    logic [NBIT-1:0]      S_DIN;
    logic                 S_VIN;
    logic                 S_RDY;
    logic [NBIT-1:0]      DIN3k, DIN3k1, DIN3k2;
    logic                 VIN;
    logic [NBIT-1:0]      DOUT3k, DOUT3k1, DOUT3k2;
    logic                 VOUT;
    logic [NBIT-1:0]      M_DOUT;
    logic                 M_VOUT;
    logic                 M_RDY;
    logic                 CFG_WE;
    logic [3:0]           CFG_ADDR;
    logic [NBIT-1:0]      CFG_DATA;
    logic                 CFG_COMMIT;
    logic                 CFG_BUSY;
    logic [NTAP*NBIT-1:0] B_ALL;
`ifdef FIR_SCHED_ERR_EN
    logic                 ERR;
    logic [15:0]          CNT_TRIP;
`endif

    // scheduler side
    modport slave (
        input  S_DIN, S_VIN, DOUT3k, DOUT3k1, DOUT3k2, VOUT, M_RDY,
               CFG_WE, CFG_ADDR, CFG_DATA, CFG_COMMIT,
        output S_RDY, DIN3k, DIN3k1, DIN3k2, VIN, M_DOUT, M_VOUT,
               CFG_BUSY, B_ALL
`ifdef FIR_SCHED_ERR_EN
        , output ERR, CNT_TRIP
`endif
    );

    // environment side (stream source/sink, filter, config host)
    modport master (
        output S_DIN, S_VIN, DOUT3k, DOUT3k1, DOUT3k2, VOUT, M_RDY,
               CFG_WE, CFG_ADDR, CFG_DATA, CFG_COMMIT,
        input  S_RDY, DIN3k, DIN3k1, DIN3k2, VIN, M_DOUT, M_VOUT,
               CFG_BUSY, B_ALL
`ifdef FIR_SCHED_ERR_EN
        , input ERR, CNT_TRIP
`endif
    );
endinterface

// File: rtl/fir_unf_sched.sv
// fir_unf_sched: packs a serial sample stream into triplets for the 3-parallel
// unfolded FIR, serializes the filter's output triplets through a credited
// FIFO, and owns the coefficient bank with drain-then-swap commits.
// Optional macro FIR_SCHED_ERR_EN: adds sticky ERR and 16-bit CNT_TRIP.
module fir_unf_sched #(
    parameter int NBIT        = 9,
    parameter int NTAP        = 11,
    parameter int OFIFO_DEPTH = 4
) (
    input  logic           CLK,
    input  logic           RST,
    fir_unf_sched_if.slave bus
);
    localparam int AW = $clog2(OFIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(OFIFO_DEPTH);
    localparam logic [CW:0]   DEPTH_S = (CW+1)'(OFIFO_DEPTH);

    typedef logic [2:0][NBIT-1:0] trip_t;
    typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_t;

    state_t                    state, state_nx;
    logic [1:0]                phase;
    logic [NBIT-1:0]           hold0, hold1;
    trip_t                     din_q;
    logic                      vin_q;
    logic [CW-1:0]             inflight, count;
    logic [AW-1:0]             wr_ptr, rd_ptr;
    logic [1:0]                sel;
    trip_t                     fifo_mem [OFIFO_DEPTH];
    trip_t                     head;
    logic [NTAP-1:0][NBIT-1:0] shadow, active;
    logic [CW:0]               credit_sum;
    logic s_rdy, s_xfer, busy, do_swap, credit_ok, vout_ok, push, pop, m_vld;

    // Credit covers both triplets inside the filter and those parked in the
    // FIFO, so the filter (which cannot stall) always has somewhere to land.
    assign credit_sum = {1'b0, count} + {1'b0, inflight};
    assign credit_ok  = credit_sum < DEPTH_S;
    assign s_xfer     = bus.S_VIN && s_rdy;
    assign vout_ok    = bus.VOUT && (inflight != '0);
    assign push       = vout_ok && (count != DEPTH_C);
    assign m_vld      = count != '0;
    assign pop        = m_vld && bus.M_RDY && (sel == 2'd2);
    assign head       = fifo_mem[rd_ptr];

    assign bus.S_RDY    = s_rdy && !RST;
    assign bus.DIN3k    = din_q[0];
    assign bus.DIN3k1   = din_q[1];
    assign bus.DIN3k2   = din_q[2];
    assign bus.VIN      = vin_q;
    assign bus.M_VOUT   = m_vld;
    assign bus.M_DOUT   = m_vld ? head[sel] : '0;
    assign bus.CFG_BUSY = busy;
    assign bus.B_ALL    = active;

    // Packer: collect two samples, launch the triplet with the third.
    always_ff @(posedge CLK) begin
        if (RST) begin
            phase <= 2'd0;
            hold0 <= '0;
            hold1 <= '0;
            din_q <= '0;
            vin_q <= 1'b0;
        end else begin
            vin_q <= 1'b0;
            if (s_xfer) begin
                case (phase)
                    2'd0: begin
                        hold0 <= bus.S_DIN;
                        phase <= 2'd1;
                    end
                    2'd1: begin
                        hold1 <= bus.S_DIN;
                        phase <= 2'd2;
                    end
                    default: begin
                        din_q <= {bus.S_DIN, hold1, hold0};
                        vin_q <= 1'b1;
                        phase <= 2'd0;
                    end
                endcase
            end
        end
    end

    // Triplets inside the filter; spurious VOUT never underflows.
    always_ff @(posedge CLK) begin
        if (RST)
            inflight <= '0;
        else if (vin_q && !vout_ok && inflight != DEPTH_C)
            inflight <= inflight + 1'b1;
        else if (!vin_q && vout_ok)
            inflight <= inflight - 1'b1;
    end

    // FIFO pointers/occupancy and the serializer lane select.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            sel    <= 2'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (m_vld && bus.M_RDY)
                sel <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
        end
    end

    // FIFO storage; lane 0 is the oldest sample of the triplet.
    always_ff @(posedge CLK) begin
        if (push)
            fifo_mem[wr_ptr] <= {bus.DOUT3k2, bus.DOUT3k1, bus.DOUT3k};
    end

    // Commit FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) state <= RUN;
        else     state <= state_nx;
    end

    // Commit FSM: finish the open triplet, wait for the filter to empty, swap.
    always_comb begin
        state_nx = state;
        s_rdy    = 1'b0;
        busy     = 1'b0;
        do_swap  = 1'b0;
        case (state)
            RUN: begin
                s_rdy = (phase == 2'd2) ? credit_ok : 1'b1;
                if (bus.CFG_COMMIT) state_nx = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (phase != 2'd0) s_rdy = (phase == 2'd2) ? credit_ok : 1'b1;
                if (phase == 2'd0 && inflight == '0 && !vin_q) state_nx = SWAP;
            end
            SWAP: begin
                busy     = 1'b1;
                do_swap  = 1'b1;
                state_nx = RUN;
            end
            default: state_nx = RUN;
        endcase
    end

    // Coefficient banks; the swap copies the shadow as it was before this edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (bus.CFG_WE && int'(bus.CFG_ADDR) < NTAP)
                shadow[bus.CFG_ADDR] <= bus.CFG_DATA;
            if (do_swap)
                active <= shadow;
        end
    end

`ifdef FIR_SCHED_ERR_EN
    logic        err_q;
    logic [15:0] cnt_trip;

    // Sticky flag for any dropped filter result; triplet counter wraps.
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q    <= 1'b0;
            cnt_trip <= '0;
        end else begin
            if ((bus.VOUT && inflight == '0) || (vout_ok && count == DEPTH_C))
                err_q <= 1'b1;
            if (vin_q)
                cnt_trip <= cnt_trip + 16'd1;
        end
    end

    assign bus.ERR      = err_q;
    assign bus.CNT_TRIP = cnt_trip;
`endif
endmodule
